// File: rtl/csa_acc_pkg.sv
// csa_acc_pkg: shared state encoding and sizing helpers for the carry-save accumulator
package csa_acc_pkg;
  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} csa_acc_state_t;
  function automatic int nch(input int acc_w, input int cpa_w);
    return acc_w / cpa_w;
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/csa_accumulator_if.sv
// csa_accumulator_if: operand stream in, resolved result stream out
//   in_valid/in_ready/in_a/in_b/in_last/clr : operand pairs and group control
//   out_valid/out_ready/out_sum/out_terms    : resolved result and beat count
//   out_ovf                                  : sticky overflow (CSA_ACC_OVF_EN only)
interface csa_accumulator_if #(parameter int BW = 8, parameter int ACC_W = 16, parameter int CNT_W = 8);
  logic in_valid, in_ready, in_last, clr, out_valid, out_ready;
  logic [BW-1:0] in_a, in_b;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_terms;
`ifdef CSA_ACC_OVF_EN
  logic out_ovf;
`endif
  modport master (
    output in_valid, in_a, in_b, in_last, clr, out_ready,
    input  in_ready, out_valid, out_sum, out_terms
`ifdef CSA_ACC_OVF_EN
    , input out_ovf
`endif
  );
  modport slave (
    input  in_valid, in_a, in_b, in_last, clr, out_ready,
    output in_ready, out_valid, out_sum, out_terms
`ifdef CSA_ACC_OVF_EN
    , output out_ovf
`endif
  );
endinterface

// File: rtl/csa_4to2.sv
// csa_4to2: two full-adder rows folding a and b into a redundant sum/carry pair
//   s_in, c_in : current redundant pair
//   a, b       : new addends
//   s_out      : next sum word
//   c_out      : next carry word, already shifted into weight position
//   co         : carries pushed past bit W-1 by level 2 and level 1
module csa_4to2 #(parameter int W = 16) (
  input  logic [W-1:0] s_in,
  input  logic [W-1:0] c_in,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s_out,
  output logic [W-1:0] c_out,
  output logic [1:0]   co
);
  logic [W-1:0] s1, c1, c1_sh, c2;
  assign c1_sh = {c1[W-2:0], 1'b0};
  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_l1 (.a(s_in[i]), .b(c_in[i]),  .ci(a[i]), .s(s1[i]),    .co(c1[i]));
    full_adder u_l2 (.a(s1[i]),   .b(c1_sh[i]), .ci(b[i]), .s(s_out[i]), .co(c2[i]));
  end
  assign c_out = {c2[W-2:0], 1'b0};
  assign co    = {c2[W-1], c1[W-1]};
endmodule

// File: rtl/full_adder.sv
// full_adder: one-bit full adder
//   a, b, ci : addend bits and carry in
//   s, co    : sum and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/csa_accumulator.sv
// csa_accumulator: carry-save accumulation of operand pairs with chunked carry-propagate resolve
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of csa_accumulator_if (operand stream in, result stream out)
//   Define CSA_ACC_OVF_EN to add the sticky out_ovf flag.
module csa_accumulator
  import csa_acc_pkg::*;
#(
  parameter int BW    = 8,
  parameter int ACC_W = 16,
  parameter int CPA_W = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  csa_accumulator_if.slave bus
);
  localparam int N  = nch(ACC_W, CPA_W);
  localparam int KW = idx_w(N);
  if (ACC_W < BW || ACC_W % CPA_W != 0) begin : g_bad_cfg
    $error("csa_accumulator: ACC_W must be >= BW and a multiple of CPA_W");
  end
  csa_acc_state_t state;
  logic [ACC_W-1:0] s_q, c_q, s_d, c_d, res, sum_q;
  logic [CNT_W-1:0] term_cnt;
  logic [KW-1:0] k;
  logic [CPA_W:0] chunk;
  logic [1:0] co;
  logic cy, rdy, vld, last_chunk, hs;
  csa_4to2 #(.W(ACC_W)) u_csa (
    .s_in(s_q), .c_in(c_q), .a(ACC_W'(bus.in_a)), .b(ACC_W'(bus.in_b)),
    .s_out(s_d), .c_out(c_d), .co(co)
  );
  assign chunk      = {1'b0, s_q[k*CPA_W +: CPA_W]} + {1'b0, c_q[k*CPA_W +: CPA_W]} + (CPA_W+1)'(cy);
  assign last_chunk = k == KW'(N - 1);
  assign hs         = vld && bus.out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      s_q      <= '0;
      c_q      <= '0;
      term_cnt <= '0;
      k        <= '0;
      cy       <= 1'b0;
      res      <= '0;
      sum_q    <= '0;
      rdy      <= 1'b1;
      vld      <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.clr) begin
            s_q      <= '0;
            c_q      <= '0;
            term_cnt <= '0;
          end else if (bus.in_valid) begin
            s_q      <= s_d;
            c_q      <= c_d;
            term_cnt <= term_cnt + CNT_W'(term_cnt != '1);
            if (bus.in_last) begin
              state <= RESOLVE;
              rdy   <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          res[k*CPA_W +: CPA_W] <= chunk[CPA_W-1:0];
          cy <= chunk[CPA_W];
          k  <= last_chunk ? '0 : k + 1'b1;
          if (last_chunk) state <= OUTPUT;
        end
        OUTPUT: begin
          // out_valid lags entry into OUTPUT by one cycle so out_sum is a clean register copy
          if (hs) begin
            state    <= ACCUM;
            rdy      <= 1'b1;
            vld      <= 1'b0;
            s_q      <= '0;
            c_q      <= '0;
            term_cnt <= '0;
            cy       <= 1'b0;
          end else begin
            vld   <= 1'b1;
            sum_q <= res;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.out_sum   = sum_q;
  assign bus.out_terms = term_cnt;
`ifdef CSA_ACC_OVF_EN
  logic ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else if ((state == ACCUM && bus.clr) || hs) ovf <= 1'b0;
    else if (state == ACCUM && bus.in_valid) ovf <= ovf | (|co);
    else if (state == RESOLVE && last_chunk) ovf <= ovf | chunk[CPA_W];
  end
  assign bus.out_ovf = ovf;
`else
  logic unused_co;
  assign unused_co = ^co;
`endif
endmodule

// File: tb/tb_csa_accumulator.sv
// tb_csa_accumulator: directed and randomized checks of csa_accumulator against an arithmetic model
module tb_csa_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int errors = 0;
  int checks = 0;
  csa_accumulator_if #(.BW(8), .ACC_W(16), .CNT_W(8)) bus ();
  csa_accumulator #(.BW(8), .ACC_W(16), .CPA_W(4), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int unsigned m_acc = 0;
  int m_cnt = 0;
  int cd = 0;
  bit m_ready = 1'b1;
  bit m_valid = 1'b0;
  int unsigned m_sum = 0;
  int m_terms = 0;
  bit m_ovf = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = 0; m_cnt = 0; cd = 0; m_ready = 1'b1; m_valid = 1'b0;
    end else if (m_ready) begin
      if (bus.clr) begin
        m_acc = 0; m_cnt = 0;
      end else if (bus.in_valid) begin
        m_acc += int'(bus.in_a) + int'(bus.in_b);
        m_cnt++;
        if (bus.in_last) begin m_ready = 1'b0; cd = 5; end
      end
    end else if (m_valid) begin
      if (bus.out_ready) begin m_valid = 1'b0; m_ready = 1'b1; m_acc = 0; m_cnt = 0; end
    end else begin
      cd--;
      if (cd == 0) begin
        m_valid = 1'b1;
        m_sum   = m_acc % 65536;
        m_terms = m_cnt > 255 ? 255 : m_cnt;
        m_ovf   = m_acc >= 65536;
      end
    end
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    check("in_ready", 64'(bus.in_ready), 64'(m_ready));
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (m_valid) begin
      check("model_out_sum", 64'(bus.out_sum), 64'(m_sum));
      check("model_out_terms", 64'(bus.out_terms), 64'(m_terms));
`ifdef CSA_ACC_OVF_EN
      check("model_out_ovf", 64'(bus.out_ovf), 64'(m_ovf));
`endif
    end
  end
  task automatic send(input int a, input int b, input bit last, input bit c = 1'b0);
    int n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("send_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1; bus.in_a = 8'(a); bus.in_b = 8'(b); bus.in_last = last; bus.clr = c;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.clr = 1'b0;
  endtask
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("wait_out_valid", 64'(bus.out_valid), 64'd1);
  endtask
  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("ready_after_hs", 64'(bus.in_ready), 64'd1);
  endtask
  initial begin
    int cyc;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_last = 1'b0; bus.clr = 1'b0; bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_sum", 64'(bus.out_sum), 64'd0);
    check("reset_out_terms", 64'(bus.out_terms), 64'd0);
    send(3, 5, 0);
    send(255, 255, 1);
    wait_out(cyc);
    check("two_beat_latency", 64'(cyc), 64'd5);
    check("two_beat_sum", 64'(bus.out_sum), 64'd518);
    check("two_beat_terms", 64'(bus.out_terms), 64'd2);
    handshake();
    for (int i = 0; i < 129; i++) send(255, 255, i == 128);
    wait_out(cyc);
    check("wrap_sum", 64'(bus.out_sum), 64'd254);
    check("wrap_terms", 64'(bus.out_terms), 64'd129);
`ifdef CSA_ACC_OVF_EN
    check("wrap_ovf", 64'(bus.out_ovf), 64'd1);
`endif
    handshake();
    for (int i = 0; i < 300; i++) send(0, 1, i == 299);
    wait_out(cyc);
    check("sat_sum", 64'(bus.out_sum), 64'd300);
    check("sat_terms", 64'(bus.out_terms), 64'd255);
`ifdef CSA_ACC_OVF_EN
    check("sat_ovf", 64'(bus.out_ovf), 64'd0);
`endif
    handshake();
    send(5, 6, 1);
    wait_out(cyc);
    for (int i = 0; i < 10; i++) begin
      check("bp_sum", 64'(bus.out_sum), 64'd11);
      check("bp_terms", 64'(bus.out_terms), 64'd1);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    handshake();
    send(1, 1, 1);
    wait_out(cyc);
    check("after_bp_sum", 64'(bus.out_sum), 64'd2);
    handshake();
    send(10, 10, 0);
    send(7, 7, 1, 1);
    check("clr_stays_accum", 64'(bus.in_ready), 64'd1);
    send(2, 0, 1);
    wait_out(cyc);
    check("clr_sum", 64'(bus.out_sum), 64'd2);
    check("clr_terms", 64'(bus.out_terms), 64'd1);
    handshake();
    send(3, 4, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    check("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send(4, 4, 1);
    wait_out(cyc);
    check("post_reset_sum", 64'(bus.out_sum), 64'd8);
    check("post_reset_terms", 64'(bus.out_terms), 64'd1);
    handshake();
    for (int i = 0; i < 4000; i++) begin
      bus.in_valid  = $urandom_range(0, 3) != 0;
      bus.in_a      = $urandom_range(0, 1) != 0 ? 8'($urandom) : 8'($urandom_range(0, 3));
      bus.in_b      = $urandom_range(0, 2) == 0 ? 8'd255 : 8'($urandom);
      bus.in_last   = $urandom_range(0, 15) == 0;
      bus.clr       = $urandom_range(0, 40) == 0;
      bus.out_ready = $urandom_range(0, 2) != 0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.clr = 1'b0; bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
